// File: rtl/multicycle_main_fsm_pkg.sv
// Shared constants for the multicycle RV32I control unit: FSM state encoding,
// opcodes, and the mux-select / ALUOp encodings also used by the ALU decoder.
// No ports; imported by the FSM, its interface and sibling decoders.
package multicycle_main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM and the datapath.
// Inputs to the FSM: op, zero, mem_ready. Outputs: mux selects, ALUOp,
// write enables, mem_req, illegal_op. master = FSM side, slave = datapath side.
interface multicycle_main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       mem_req;
  logic       illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
           RegWrite, MemWrite, mem_req, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
           RegWrite, MemWrite, mem_req, illegal_op
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Latency: beq 3, R/I/jal/sw 4, lw 5 cycles; outputs combinational from state.
// Backpressure: mem_ready=0 holds FETCH/MEMREAD/MEMWRITE, one cycle per stall.
// Ports: clk, rst (sync, active-high), bus (master modport of the control bundle).
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  multicycle_main_fsm_if.master bus
);

  state_t state_q, state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ALUOp      = ALUOP_ADD;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_REG;
    bus.ResultSrc  = RES_ALUOUT;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.illegal_op = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.mem_req   = 1'b1;
        // IR and PC may only advance once the fetch actually returns data.
        bus.IRWrite   = bus.mem_ready;
        pc_update     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.illegal_op = !((bus.op == OP_LW) || (bus.op == OP_SW) ||
                           (bus.op == OP_R)  || (bus.op == OP_I)  ||
                           (bus.op == OP_BEQ) || (bus.op == OP_JAL));
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.mem_req = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.mem_req  = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BEQ: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUOp   = ALUOP_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase

    bus.PCWrite = pc_update | (branch & bus.zero);

    // Reset overrides everything so an in-flight store or writeback is dropped.
    if (rst) begin
      bus.ALUOp      = 2'b00;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ResultSrc  = 2'b00;
      bus.AdrSrc     = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.PCWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.mem_req    = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: instruction-level reference
// model produces per-cycle expected outputs into a queue; a monitor compares.
module tb_multicycle_main_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_main_fsm_if bus();

  multicycle_main_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       mreq;
    logic       ill;
  } out_t;

  typedef enum int {
    PH_RST, PH_FSTALL, PH_F, PH_D, PH_DILL, PH_MA, PH_MRSTALL, PH_MR, PH_MWB,
    PH_MWSTALL, PH_MW, PH_ER, PH_EI, PH_AWB, PH_BQ, PH_J
  } ph_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  out_t exp_q[$];
  ph_t  ph_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected control word for one cycle of a given instruction phase.
  function automatic out_t expect_for(ph_t p, logic z);
    out_t o;
    o = '0;
    case (p)
      PH_FSTALL:  begin o.srcb = 2'b10; o.res = 2'b10; o.mreq = 1'b1; end
      PH_F:       begin o.srcb = 2'b10; o.res = 2'b10; o.mreq = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; end
      PH_D:       begin o.srca = 2'b01; o.srcb = 2'b01; end
      PH_DILL:    begin o.srca = 2'b01; o.srcb = 2'b01; o.ill = 1'b1; end
      PH_MA:      begin o.srca = 2'b10; o.srcb = 2'b01; end
      PH_MRSTALL,
      PH_MR:      begin o.adr = 1'b1; o.mreq = 1'b1; end
      PH_MWB:     begin o.res = 2'b01; o.regw = 1'b1; end
      PH_MWSTALL,
      PH_MW:      begin o.adr = 1'b1; o.memw = 1'b1; o.mreq = 1'b1; end
      PH_ER:      begin o.srca = 2'b10; o.aluop = 2'b10; end
      PH_EI:      begin o.srca = 2'b10; o.srcb = 2'b01; o.aluop = 2'b10; end
      PH_AWB:     begin o.regw = 1'b1; end
      PH_BQ:      begin o.srca = 2'b10; o.aluop = 2'b01; o.pcw = z; end
      PH_J:       begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom);
    while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
    return o;
  endfunction

  // One clock cycle of stimulus; expected outputs for that cycle are queued.
  task automatic cycle(input ph_t p, input logic mr, input logic r,
                       input logic [6:0] op, input logic z);
    @(posedge clk);
    #1;
    rst           = r;
    bus.op        = op;
    bus.mem_ready = mr;
    bus.zero      = z;
    exp_q.push_back(r ? out_t'('0) : expect_for(p, z));
    ph_q.push_back(r ? PH_RST : p);
  endtask

  // zsel: 0/1 forces zero, otherwise random. rst_at: cycle index to reset at.
  task automatic run_instr(input int kind, input logic [6:0] ill_op, input int fst,
                           input int mst, input int zsel, input int rst_at);
    ph_t        seq[$];
    logic [6:0] op;
    logic       mr, z;
    case (kind)
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_BEQ:   op = 7'b1100011;
      K_JAL:   op = 7'b1101111;
      default: op = ill_op;
    endcase
    for (int i = 0; i < fst; i++) seq.push_back(PH_FSTALL);
    seq.push_back(PH_F);
    seq.push_back(kind == K_ILL ? PH_DILL : PH_D);
    case (kind)
      K_LW: begin
        seq.push_back(PH_MA);
        for (int i = 0; i < mst; i++) seq.push_back(PH_MRSTALL);
        seq.push_back(PH_MR);
        seq.push_back(PH_MWB);
      end
      K_SW: begin
        seq.push_back(PH_MA);
        for (int i = 0; i < mst; i++) seq.push_back(PH_MWSTALL);
        seq.push_back(PH_MW);
      end
      K_R:   begin seq.push_back(PH_ER); seq.push_back(PH_AWB); end
      K_I:   begin seq.push_back(PH_EI); seq.push_back(PH_AWB); end
      K_BEQ: seq.push_back(PH_BQ);
      K_JAL: begin seq.push_back(PH_J); seq.push_back(PH_AWB); end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      z = (zsel == 0) ? 1'b0 : (zsel == 1) ? 1'b1 : 1'($urandom);
      if (i == rst_at) begin
        cycle(PH_RST, 1'($urandom), 1'b1, op, z);
        return;
      end
      if (seq[i] == PH_FSTALL || seq[i] == PH_MRSTALL || seq[i] == PH_MWSTALL) mr = 1'b0;
      else if (seq[i] == PH_F || seq[i] == PH_MR || seq[i] == PH_MW)           mr = 1'b1;
      else                                                                      mr = 1'($urandom);
      cycle(seq[i], mr, 1'b0, op, z);
    end
  endtask

  // Monitor: compares the DUT control word against the queued expectation.
  always @(negedge clk) begin
    out_t e, a;
    ph_t  p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = ph_q.pop_front();
      a = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
           bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.mem_req,
           bus.illegal_op};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s at %0t: got %b required %b", p.name(), $time, a, e);
      end
    end
  end

  initial begin
    int kind, fst, mst, ra;
    rst           = 1'b1;
    bus.op        = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset held for two cycles: all outputs zero.
    cycle(PH_RST, 1'b1, 1'b1, 7'd0, 1'b0);
    cycle(PH_RST, 1'b0, 1'b1, 7'd0, 1'b1);

    // Directed cases.
    run_instr(K_LW,  7'd0, 0, 0, 2, -1);
    run_instr(K_BEQ, 7'd0, 0, 0, 1, -1);
    run_instr(K_BEQ, 7'd0, 0, 0, 0, -1);
    run_instr(K_R,   7'd0, 0, 0, 2, -1);
    run_instr(K_I,   7'd0, 0, 0, 2, -1);
    run_instr(K_R,   7'd0, 3, 0, 2, -1);
    run_instr(K_SW,  7'd0, 0, 2, 2, -1);
    run_instr(K_ILL, 7'b1111111, 0, 0, 2, -1);
    run_instr(K_JAL, 7'd0, 0, 0, 2, -1);
    run_instr(K_LW,  7'd0, 1, 2, 2, -1);
    // Reset while stalled in MEMWRITE (F, D, MA, MW-stall -> index 3).
    run_instr(K_SW,  7'd0, 0, 2, 2, 3);
    run_instr(K_I,   7'd0, 0, 0, 2, -1);
    // Two-cycle reset mid-instruction, then recovery.
    run_instr(K_R,   7'd0, 0, 0, 2, 2);
    cycle(PH_RST, 1'b1, 1'b1, 7'd0, 1'b1);
    run_instr(K_BEQ, 7'd0, 0, 0, 1, -1);

    // Randomized instruction stream with occasional resets.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 6);
      fst  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      mst  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      ra   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
      run_instr(kind, rand_illegal(), fst, mst, 2, ra);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
